fifo_drain_arb: RTL and testbench
=================================

# fifo_drain_arb

Round-robin drain arbiter that empties up to N_SRC `fifo_sync` instances into one valid/ready output stream. It sits between a bank of per-lane sync FIFOs and a single downstream consumer, such as a shared NN compute port or a writeback bus. It drives each FIFO's `rd_en`, absorbs the FIFOs' fixed 1-cycle read latency, and tags every word with its source index. Throughput is one word per cycle.

## Interface
Parameters:
- N_SRC, 4: number of source FIFOs; legal range 2..16.
- DATA_WIDE, 64: word width; must match the source FIFOs.
- SRC_W, $clog2(N_SRC): width of the source tag (derived parameter).

Ports:
- clk, input, 1: single clock; all logic is on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- src_empty, input, N_SRC: `empty` from each source FIFO.
- src_rd_en, output, N_SRC: `rd_en` to each source FIFO; at most one bit is high per cycle.
- src_dout, input, N_SRC*DATA_WIDE: concatenated FIFO `dout`; source i occupies bits [i*DATA_WIDE +: DATA_WIDE].
- out_valid, output, 1: the output word is valid.
- out_data, output, DATA_WIDE: output word.
- out_src, output, SRC_W: source index of `out_data`.
- out_ready, input, 1: consumer accepts the word; a transfer occurs when out_valid && out_ready.

## Operation
- **Pick.** A source is eligible when its `src_empty` bit is 0. The search starts at `last_grant`+1 and wraps modulo N_SRC. The first eligible source wins. `last_grant` updates to the winner on every issue.
- **Issue condition.** Let `occ` be the skid occupancy (0..2), `infl` be 1 if a read was issued in the previous cycle, and `pop` be out_valid && out_ready. A read is issued this cycle iff some source is eligible and (occ + infl − pop) ≤ 1.
- **On issue.** Assert `src_rd_en[winner]` for exactly one cycle, then register `infl`=1 and `infl_src`=winner.
- **Capture.** In the cycle after an issue, the FIFO presents the word on `src_dout`. Push {src_dout[infl_src], infl_src} into the 2-entry skid buffer at the next clock edge.
- **Output.** `out_data` and `out_src` show the skid head; out_valid = (occ ≠ 0).
- **Skid buffer.** Simultaneous push and pop are allowed: occupancy stays the same and order is preserved.
- **Never-read-empty rule.** `src_rd_en[i]` must never assert while `src_empty[i]`=1. This guarantees the FIFO's zero-fill path on an empty read is never exercised.
- **Same-source reads.** Back-to-back reads of the same source are legal, because `src_empty` already reflects the previous cycle's read.
- **Backpressure.** With out_ready=0 and occ=2, no reads are issued. Data is never dropped and never duplicated.
- **Reset.** Asserting rst_n mid-operation clears occ, infl and the buffer contents. Any in-flight word is discarded (the source FIFOs share the same reset).

## Timing
- Reset values:
  - src_rd_en = 0
  - out_valid = 0
  - out_data = 0
  - out_src = 0
  - last_grant = N_SRC−1, so source 0 is picked first.
- Latency: `src_empty[i]` falling in cycle t (arbiter idle) gives `src_rd_en[i]` in cycle t, `src_dout` valid in t+1, and out_valid in t+2.
- `src_rd_en` is combinational from registered state and `src_empty` only. It has no path from `out_ready` other than through `pop`.
- Sustained throughput: 1 word/cycle with out_ready held high and any source non-empty.
- Fairness: under continuous demand, each of k active sources receives a grant at least once every k issues.

## Configuration
- FIFO_DRAIN_ARB_FIXED_PRIO_EN defined: the pick uses fixed priority, with the lowest eligible index winning. `last_grant` is unused and optimised away.
- Not defined (default): round-robin as described under Operation.
- Ports and timing are identical in both modes.

## Structure
- Package `fifo_drain_arb_pkg` holds:
  - the skid entry typedef, a struct {data, src} parameterised via a localparam width;
  - the default N_SRC and DATA_WIDE.
- One sub-module, `fifo_drain_arb_pick`: a combinational rotate-priority picker. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index. The macro's effect is confined to this sub-module.

## Test plan
- **Single word, source 2:** src_empty=4'b1011, one word 0xA5 queued, out_ready=1. Expect `src_rd_en`=4'b0100 for 1 cycle, then out_valid with out_data=0xA5 and out_src=2 two cycles later.
- **Round-robin interleave:** all 4 FIFOs hold 3 words each, out_ready=1. Expect out_src sequence 0,1,2,3,0,1,2,3,0,1,2,3 on 12 consecutive cycles.
- **Backpressure:** source 0 holds 5 words, out_ready=0 for 10 cycles. Expect exactly 2 `rd_en` pulses, then out_valid held with the first word. After release, all 5 words arrive in order with no gaps.
- **Last-word drain:** source 1 holds 1 word; it is read in cycle t. Expect no `src_rd_en[1]` in t+1 (empty is high), and no zero word is ever emitted.
- **Reset mid-stream:** assert rst_n during a read in flight. Expect all outputs 0 during reset, and after release the first grant goes to source 0.
- **Fixed-priority build:** with FIFO_DRAIN_ARB_FIXED_PRIO_EN defined, sources 0 and 3 continuously non-empty. Expect out_src always 0 until source 0 empties.

Source files
------------

// File: rtl/fifo_drain_arb_pkg.sv
// fifo_drain_arb_pkg: shared types and defaults for the FIFO drain arbiter.
// The skid entry is sized for the widest supported configuration. Narrower
// instances zero-extend into it, and the unused upper bits are left for
// synthesis to trim.
package fifo_drain_arb_pkg;

    localparam int N_SRC_DEF     = 4;
    localparam int DATA_WIDE_DEF = 64;
    localparam int N_SRC_MAX     = 16;

    localparam int SKID_DATA_W   = DATA_WIDE_DEF;
    localparam int SKID_SRC_W    = $clog2(N_SRC_MAX);

    typedef struct packed {
        logic [SKID_DATA_W-1:0] data;
        logic [SKID_SRC_W-1:0]  src;
    } skid_entry_t;

endpackage

// File: rtl/fifo_drain_arb_pick.sv
// fifo_drain_arb_pick: combinational picker for the drain arbiter.
// Default build: rotate-priority search starting at last_grant+1.
// FIFO_DRAIN_ARB_FIXED_PRIO_EN: fixed priority, lowest requesting index wins.
// In that build last_grant is ignored.
module fifo_drain_arb_pick #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] last_grant,
    output logic [N_SRC-1:0] grant,
    output logic [SRC_W-1:0] grant_idx
);

    logic             found;

`ifdef FIFO_DRAIN_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Lowest eligible index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0] cand;

    // Search from the source after the previous winner and wrap around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SRC_W'((int'(last_grant) + k) % N_SRC);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_drain_arb.sv
// fifo_drain_arb: drains a bank of sync FIFOs into one valid/ready stream.
// A read is issued only when the 2-entry skid buffer is guaranteed to have
// room for the word, counting the word already in flight. This hides the
// FIFOs' 1-cycle read latency and keeps full throughput.
// The FIFO_DRAIN_ARB_FIXED_PRIO_EN macro selects fixed priority in the picker.
module fifo_drain_arb
    import fifo_drain_arb_pkg::*;
#(
    parameter int N_SRC     = N_SRC_DEF,
    parameter int DATA_WIDE = DATA_WIDE_DEF,
    parameter int SRC_W     = $clog2(N_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC-1:0]         src_empty,
    output logic [N_SRC-1:0]         src_rd_en,
    input  logic [N_SRC*DATA_WIDE-1:0] src_dout,
    output logic                     out_valid,
    output logic [DATA_WIDE-1:0]     out_data,
    output logic [SRC_W-1:0]         out_src,
    input  logic                     out_ready
);

    if (N_SRC < 2 || N_SRC > N_SRC_MAX || DATA_WIDE > SKID_DATA_W) begin : g_bad_cfg
        $error("fifo_drain_arb: unsupported N_SRC/DATA_WIDE");
    end

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] grant;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] last_grant;
    logic             issue;
    logic             pop;
    logic [2:0]       load_p0;

    // Read issued last cycle: the word lands on src_dout this cycle.
    logic             vld_p1;
    logic [SRC_W-1:0] src_p1;

    // Skid buffer; entry 0 is the head.
    skid_entry_t      skid_p2 [2];
    logic [1:0]       occ;
    logic             push;
    skid_entry_t      push_entry;
    logic             unused_head;

    assign req = ~src_empty;

    fifo_drain_arb_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Stage 0: issue decision and FIFO read strobe.
    assign pop     = (occ != 2'd0) && out_ready;
    assign load_p0 = {1'b0, occ} + {2'b00, vld_p1};
    assign issue   = rst_n && (|req) && (load_p0 <= 3'd1 + {2'b00, pop});
    assign src_rd_en = issue ? grant : '0;

    // Track the in-flight read and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            src_p1     <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                src_p1     <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Stage 1: capture the word that the FIFO presents one cycle after the read.
    assign push            = vld_p1;
    assign push_entry.data = SKID_DATA_W'(src_dout[int'(src_p1)*DATA_WIDE +: DATA_WIDE]);
    assign push_entry.src  = SKID_SRC_W'(src_p1);

    // Skid buffer. Push and pop in the same cycle keep occupancy unchanged and preserve order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            skid_p2[0] <= '0;
            skid_p2[1] <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            unique case (occ)
                2'd0: if (push) skid_p2[0] <= push_entry;
                2'd1: if (push) begin
                    if (pop) skid_p2[0] <= push_entry;
                    else     skid_p2[1] <= push_entry;
                end
                2'd2: if (pop) begin
                    skid_p2[0] <= skid_p2[1];
                    if (push) skid_p2[1] <= push_entry;
                end
                default: ;
            endcase
        end
    end

    // Stage 2: the output shows the skid head.
    assign out_valid   = (occ != 2'd0);
    assign out_data    = skid_p2[0].data[DATA_WIDE-1:0];
    assign out_src     = skid_p2[0].src[SRC_W-1:0];
    assign unused_head = ^skid_p2[0];

endmodule

// File: tb/tb_fifo_drain_arb.sv
// tb_fifo_drain_arb: scoreboard bench for fifo_drain_arb with behavioural sync FIFOs.
// Build with FIFO_DRAIN_ARB_FIXED_PRIO_EN to expect the fixed-priority ordering.
module tb_fifo_drain_arb;

    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   src_empty = '1;
    logic [N-1:0]   src_rd_en;
    logic [N*W-1:0] src_dout = '0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    typedef logic [W-1:0] word_q_t [$];
    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   src;
    } exp_t;

    word_q_t fq [N];
    exp_t    exp_q [$];
    int      pop_cyc [$];
    int      rd_cnt [N];
    int      cyc = 0;
    int      n_chk = 0;
    int      n_pass = 0;

    always #5 clk = ~clk;

    fifo_drain_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_empty (src_empty),
        .src_rd_en (src_rd_en),
        .src_dout  (src_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Queue a word in a source FIFO and record it as the next expected output.
    task automatic load(input int s, input logic [W-1:0] d);
        fq[s].push_back(d);
        exp_q.push_back('{data: d, src: 2'(s)});
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sync FIFO model: rd_en pops at the edge, dout is valid the next cycle,
    // and empty reflects the read immediately after the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            src_empty <= '1;
            src_dout  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (src_rd_en[i]) begin
                    if (fq[i].size() != 0) src_dout[i*W +: W] <= fq[i].pop_front();
                    else                   src_dout[i*W +: W] <= '0;
                end
                src_empty[i] <= (fq[i].size() == 0);
            end
        end
    end

    // Monitor: read-strobe legality and scoreboard comparison on every transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (src_rd_en != '0) begin
                check("rd_onehot", 64'($onehot(src_rd_en)), 64'd1);
                check("rd_while_empty", 64'(src_rd_en & src_empty), 64'd0);
                for (int i = 0; i < N; i++) if (src_rd_en[i]) rd_cnt[i]++;
            end
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 64'hDEAD_0000_0000_DEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_src", 64'(out_src), 64'(e.src));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1);
    end

    initial begin
        int p0;
        int b;
        int seen;

        rst_n     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(src_rd_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Round-robin interleave: 4 sources x 3 words, expect 0,1,2,3 repeating.
        p0 = pop_cyc.size();
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < N; s++)
                load(s, 64'h1000 + 64'(s * 16 + r));
        wait_drain(100);
        check("rr_count", 64'(pop_cyc.size() - p0), 64'd12);
        if (pop_cyc.size() >= p0 + 12)
            check("rr_gapless", 64'(pop_cyc[p0+11] - pop_cyc[p0]), 64'd11);

        // Single word from source 2: read strobe at t, out_valid at t+2.
        @(negedge clk);
        load(2, 64'hA5);
        @(negedge clk);
        check("single_rd", 64'(src_rd_en), 64'b0100);
        @(negedge clk);
        check("single_rd_off", 64'(src_rd_en), 64'd0);
        check("single_early_vld", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("single_vld", 64'(out_valid), 64'd1);
        check("single_data", out_data, 64'hA5);
        check("single_src", 64'(out_src), 64'd2);
        wait_drain(20);

        // Backpressure: only two reads fit, head holds the first word.
        out_ready = 1'b0;
        b = rd_cnt[0];
        for (int i = 0; i < 5; i++) load(0, 64'hB000 + 64'(i));
        repeat (10) @(negedge clk);
        check("bp_rd_pulses", 64'(rd_cnt[0] - b), 64'd2);
        check("bp_hold_vld", 64'(out_valid), 64'd1);
        check("bp_hold_data", out_data, 64'hB000);
        p0 = pop_cyc.size();
        out_ready = 1'b1;
        wait_drain(50);
        check("bp_count", 64'(pop_cyc.size() - p0), 64'd5);
        if (pop_cyc.size() >= p0 + 5)
            check("bp_gapless", 64'(pop_cyc[p0+4] - pop_cyc[p0]), 64'd4);

        // Last word of source 1: exactly one read, no zero word afterwards.
        b = rd_cnt[1];
        load(1, 64'h77);
        repeat (6) @(negedge clk);
        check("last_rd_pulses", 64'(rd_cnt[1] - b), 64'd1);
        wait_drain(20);

        // Reset with a read in flight; afterwards source 0 is granted first.
        for (int i = 0; i < 3; i++) load(0, 64'hC000 + 64'(i));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (src_rd_en != '0) begin
                seen = 1;
                break;
            end
        end
        check("rst_rd_seen", 64'(seen), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int s = 0; s < N; s++) fq[s].delete();
        exp_q.delete();
        #1;
        check("midrst_rd_en", 64'(src_rd_en), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", out_data, 64'd0);
        check("midrst_src", 64'(out_src), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load(0, 64'hD0);
        load(1, 64'hD1);
        @(negedge clk);
        check("post_rst_first", 64'(src_rd_en), 64'b0001);
        wait_drain(20);

        // Sources 0 and 3 busy at once: ordering depends on the build.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef FIFO_DRAIN_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) load(0, 64'hE000 + 64'(i));
        for (int i = 0; i < 4; i++) load(3, 64'hE300 + 64'(i));
`else
        for (int i = 0; i < 4; i++) begin
            load(0, 64'hE000 + 64'(i));
            load(3, 64'hE300 + 64'(i));
        end
`endif
        p0 = pop_cyc.size();
        wait_drain(60);
        check("prio_count", 64'(pop_cyc.size() - p0), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
